rrp_arbiter_burst: RTL and testbench

- Parametrised successor to the round-robin readout arbiter in the TPX3 readout core.
- Merges CH_NO first-word-fall-through FIFO sources (RX channels, timestamps, counter) into one 32-bit stream toward the SiTCP/USB FIFO.
- Adds over the previous arbiter:
  - a selectable fixed-priority mode;
  - a bounded burst length per grant;
  - per-channel enable masking;
  - an output buffer that decouples READY_OUT from the grant path.

---
 rtl/rrp_arbiter_burst_pkg.sv | 39 +++
 rtl/rrp_arbiter_burst_out_fifo.sv | 69 ++++++
 rtl/rrp_arbiter_burst.sv | 165 ++++++++++++++++
 tb/tb_rrp_arbiter_burst.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrp_arbiter_burst_pkg.sv
// Shared definitions for the burst round-robin readout arbiter:
// FSM state encoding, channel index width and the wrap-around
// first-set-bit search used by round-robin and fixed-priority selection.
package rrp_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of a channel index; covers up to 32 channels.
    localparam int CH_IDX_W = 5;
    // Request vectors are zero-padded to this width before searching.
    localparam int MAX_CH   = 32;

    // Returns the first index i with vec[i] set, scanning start, start+1, ...
    // and wrapping modulo n. Only the first n positions are considered.
    // Returns start when no bit is set; callers qualify with |vec.
    function automatic logic [CH_IDX_W-1:0] first_set_from(
        input logic [MAX_CH-1:0]   vec,
        input logic [CH_IDX_W-1:0] start,
        input int unsigned         n
    );
        logic [CH_IDX_W-1:0] pick;
        logic [CH_IDX_W-1:0] idx;
        logic                found;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            idx = CH_IDX_W'((32'(start) + k) % n);
            if (k < n && !found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rrp_arbiter_burst_out_fifo.sv
// Small synchronous FIFO that buffers granted words toward the
// downstream sink. Power-of-two depth, pointers wrap naturally.
// Push when full and pop when empty are ignored.
module arb_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     pop_i,
    output logic [DATA_WIDTH-1:0]    head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // An empty buffer presents zero so the output bus is quiet when idle.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; push and pop together keep the count.
    always_comb begin
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rrp_arbiter_burst.sv
// Burst round-robin / fixed-priority readout arbiter. Merges CH_NO
// first-word-fall-through sources into one stream through a small output
// buffer. Arbitration only looks at the registered buffer count, so
// READY_OUT never reaches READ_GRANT combinationally.
//
// Output handshake: a word transfers on every rising edge where
// WRITE_OUT and READY_OUT are both high; WRITE_OUT/DATA_OUT stay stable
// until that happens. READ_GRANT[i] is a read strobe: the source must
// present its next word on DATA_IN the cycle after a strobe.
module rrp_arbiter_burst
    import rrp_arbiter_pkg::*;
#(
    parameter int CH_NO      = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    input  logic [CH_NO-1:0]            WRITE_REQ,
    input  logic [CH_NO-1:0]            HOLD_REQ,
    input  logic [CH_NO-1:0]            CH_ENABLE,
    input  logic                        PRIORITY_MODE,
    input  logic [CH_NO*DATA_WIDTH-1:0] DATA_IN,
    output logic [CH_NO-1:0]            READ_GRANT,
    input  logic                        READY_OUT,
    output logic                        WRITE_OUT,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic [CH_IDX_W-1:0]         CURRENT_CH,
    output logic                        BUSY
);

    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(OUT_DEPTH);
    localparam logic [7:0]          BURST_C    = 8'(BURST_LEN);
    localparam logic [CH_IDX_W-1:0] LAST_CH    = CH_IDX_W'(CH_NO - 1);

    arb_state_e            state_q, state_d;
    logic [CH_IDX_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CH_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;

    logic [MAX_CH-1:0]     req_pad;
    logic [MAX_CH-1:0]     hold_pad;
    logic                  any_req;
    logic                  room;
    logic [CH_IDX_W-1:0]   rr_pick;
    logic [CH_IDX_W-1:0]   fp_pick;
    logic [CH_IDX_W-1:0]   next_ptr;
    logic [7:0]            burst_inc;
    logic [7:0]            cnt_after;
    logic                  grant_fire;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Effective requests and hold flags, zero-padded for the index search.
    always_comb begin
        req_pad              = '0;
        hold_pad             = '0;
        req_pad[CH_NO-1:0]   = WRITE_REQ & CH_ENABLE;
        hold_pad[CH_NO-1:0]  = HOLD_REQ;
    end

    assign any_req   = |req_pad;
    assign room      = (fifo_count < DEPTH_C);
    assign rr_pick   = first_set_from(req_pad, rr_ptr_q, CH_NO);
    assign fp_pick   = first_set_from(req_pad, '0, CH_NO);
    assign next_ptr  = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
    // The counter saturates at BURST_LEN so held bursts never wrap it.
    assign burst_inc = (burst_cnt_q < BURST_C) ? burst_cnt_q + 8'd1 : burst_cnt_q;

    // Arbitration FSM: pick a channel in IDLE, stream its words in BURST.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        cnt_after   = burst_cnt_q;
        grant_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (room && any_req) begin
                    cur_ch_d = PRIORITY_MODE ? fp_pick : rr_pick;
                    state_d  = BURST;
                end
            end
            BURST: begin
                grant_fire = req_pad[cur_ch_q] & room;
                if (grant_fire) begin
                    cnt_after = burst_inc;
                end
                burst_cnt_d = cnt_after;
                if (!req_pad[cur_ch_q] ||
                    (cnt_after >= BURST_C && !hold_pad[cur_ch_q])) begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, selected channel, round-robin pointer and burst counter.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Route the granted channel's word toward the output buffer.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CH_NO; i++) begin
            if (cur_ch_q == CH_IDX_W'(i)) begin
                sel_data = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot read strobe, forced low while reset is asserted.
    for (genvar g = 0; g < CH_NO; g++) begin : g_grant
        assign READ_GRANT[g] = grant_fire & ~BUS_RST & (cur_ch_q == CH_IDX_W'(g));
    end

    assign fifo_push = grant_fire & ~fifo_full & ~BUS_RST;
    assign fifo_pop  = ~fifo_empty & READY_OUT;

    arb_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i       (BUS_CLK),
        .rst_i       (BUS_RST),
        .push_i      (fifo_push),
        .push_data_i (sel_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign WRITE_OUT  = ~fifo_empty;
    assign DATA_OUT   = fifo_head;
    assign CURRENT_CH = cur_ch_q;
    assign BUSY       = (state_q == BURST);

endmodule

// File: tb/tb_rrp_arbiter_burst.sv
// Bench for rrp_arbiter_burst: directed scenarios plus a randomized run.
// A behavioural arbiter model pushes every expected output word into a
// queue; an independent monitor pops and compares whenever the DUT
// hands a word downstream.
module tb_rrp_arbiter_burst;

    localparam int CH    = 4;
    localparam int DW    = 32;
    localparam int BL    = 2;
    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     wreq = '0;
    logic [CH-1:0]     hreq = '0;
    logic [CH-1:0]     en = '1;
    logic              prio = 1'b0;
    logic [CH*DW-1:0]  din = '0;
    logic              ready = 1'b0;
    logic [CH-1:0]     grant;
    logic              wout;
    logic [DW-1:0]     dout;
    logic [4:0]        cur;
    logic              busy;

    always #5 clk = ~clk;

    rrp_arbiter_burst #(
        .CH_NO      (CH),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .OUT_DEPTH  (DEPTH)
    ) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .WRITE_REQ     (wreq),
        .HOLD_REQ      (hreq),
        .CH_ENABLE     (en),
        .PRIORITY_MODE (prio),
        .DATA_IN       (din),
        .READ_GRANT    (grant),
        .READY_OUT     (ready),
        .WRITE_OUT     (wout),
        .DATA_OUT      (dout),
        .CURRENT_CH    (cur),
        .BUSY          (busy)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner < 0 means nobody holds the output path (arbitration cycle).
    int owner     = -1;
    int words     = 0;
    int ptr       = 0;
    int model_cur = 0;
    int model_cnt = 0;
    logic [CH-1:0] m_req;
    logic [CH-1:0] m_grant;
    bit            m_room;
    bit            m_pop;
    int            m_pick;
    int            m_c;

    always begin
        @(negedge clk);
        #1;
        m_req = wreq & en;
        if (rst) begin
            check("grant_in_reset", 32'(grant), 32'd0);
            owner     = -1;
            words     = 0;
            ptr       = 0;
            model_cur = 0;
            model_cnt = 0;
            exp_q.delete();
        end else begin
            check("busy", 32'(busy), 32'(owner >= 0));
            check("current_ch", 32'(cur), 32'(model_cur));
            m_room  = (model_cnt < DEPTH);
            m_pop   = (model_cnt > 0) && ready;
            m_grant = '0;
            if (owner < 0) begin
                if (m_room && m_req != '0) begin
                    m_pick = -1;
                    for (int k = 0; k < CH; k++) begin
                        m_c = prio ? k : (ptr + k) % CH;
                        if (m_pick < 0 && m_req[m_c]) m_pick = m_c;
                    end
                    owner     = m_pick;
                    model_cur = m_pick;
                    words     = 0;
                end
            end else begin
                if (m_req[owner] && m_room) begin
                    m_grant[owner] = 1'b1;
                    exp_q.push_back(din[owner*DW +: DW]);
                    words++;
                    model_cnt++;
                end
                if (!m_req[owner] || (words >= BL && !hreq[owner])) begin
                    ptr   = (owner + 1) % CH;
                    owner = -1;
                    words = 0;
                end
            end
            check("read_grant", 32'(grant), 32'(m_grant));
            if (m_pop) model_cnt--;
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        check("write_out", 32'(wout), 32'(exp_q.size() != 0));
        if (wout && exp_q.size() != 0) begin
            check("data_out", dout, exp_q[0]);
            if (ready) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) din[i*DW +: DW] = $urandom;
    endtask

    task automatic do_reset();
        next_cycle();
        rst   = 1'b1;
        wreq  = '0;
        hreq  = '0;
        en    = '1;
        prio  = 1'b0;
        ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic int grant_idx(input logic [CH-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < CH; i++) if (g[i]) r = i;
        return r;
    endfunction

    int rr_exp[14] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};
    int cnt;

    // ---------------- stimulus ----------------
    initial begin
        // Round robin, all channels requesting, sink always ready.
        do_reset();
        wreq  = '1;
        ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) next_cycle();
            #3;
            check("rr_order", 32'(grant_idx(grant)), 32'(rr_exp[c]));
        end

        // Fixed priority: channel 1 starves channel 3.
        do_reset();
        prio = 1'b1;
        wreq = 4'b1010;
        cnt  = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) next_cycle();
            #3;
            if (grant[1]) cnt++;
            if (c == 19) check("fp_ch3_never", 32'(grant[3]), 32'd0);
        end
        check("fp_ch1_words", 32'(cnt), 32'd13);
        prio = 1'b0;

        // Backpressure: only OUT_DEPTH words accepted, then drain.
        do_reset();
        wreq  = 4'b0001;
        ready = 1'b0;
        cnt   = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            #3;
            if (grant[0]) cnt++;
        end
        check("bp_grants", 32'(cnt), 32'(DEPTH));
        next_cycle();
        ready = 1'b1;
        repeat (12) next_cycle();

        // Hold extends a burst; masking the held channel ends it at once.
        do_reset();
        wreq = 4'b1100;
        hreq = 4'b0100;
        cnt  = 0;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next_cycle();
            #3;
            if (grant == 4'b0100) cnt++;
        end
        check("hold_words", 32'(cnt), 32'd10);
        next_cycle();
        en = 4'b1011;
        #3;
        check("mask_no_grant", 32'(grant), 32'd0);
        next_cycle();
        #3;
        check("mask_bubble", 32'(grant), 32'd0);
        next_cycle();
        #3;
        check("mask_next_ch3", 32'(grant), 32'b1000);
        en   = '1;
        hreq = '0;

        // Reset in the middle of a burst with three words buffered.
        do_reset();
        wreq  = '1;
        ready = 1'b0;
        repeat (5) next_cycle();
        rst = 1'b1;
        #3;
        check("rst_same_cycle_grant", 32'(grant), 32'd0);
        next_cycle();
        rst = 1'b0;
        #3;
        check("rst_write_out", 32'(wout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_current_ch", 32'(cur), 32'd0);
        check("rst_data_out", dout, 32'd0);
        next_cycle();
        #3;
        check("rst_next_grant_ch0", 32'(grant), 32'b0001);
        ready = 1'b1;

        // Request drop after one word moves the pointer past the channel.
        do_reset();
        wreq = 4'b0010;
        next_cycle();
        #3;
        check("drop_first_word", 32'(grant), 32'b0010);
        next_cycle();
        wreq = 4'b0101;
        #3;
        check("drop_exit", 32'(grant), 32'd0);
        next_cycle();
        #3;
        check("drop_bubble", 32'(grant), 32'd0);
        next_cycle();
        #3;
        check("drop_next_ch2", 32'(grant), 32'b0100);

        // Randomized traffic, backpressure, masking, holds and resets.
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 3) == 0) wreq[i] = ~wreq[i];
                if ($urandom_range(0, 9) == 0) hreq[i] = ~hreq[i];
                en[i] = ($urandom_range(0, 15) != 0);
            end
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) prio = ~prio;
        end

        // Drain everything and confirm nothing is left over.
        next_cycle();
        rst   = 1'b0;
        wreq  = '0;
        hreq  = '0;
        en    = '1;
        ready = 1'b1;
        repeat (12) next_cycle();
        #3;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_write_out", 32'(wout), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
